// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 exception/interrupt controller:
// register indices, exception codes, field positions and word packers.
package cp0_pkg;

    // CP0 register indices
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Exception codes carried down the pipeline
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // Field bit positions
    localparam int SR_IM_HI    = 15;
    localparam int SR_IM_LO    = 10;
    localparam int SR_EXL      = 1;
    localparam int SR_IE       = 0;
    localparam int CAUSE_BD    = 31;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_EC_HI = 6;
    localparam int CAUSE_EC_LO = 2;

    // Exception handler entry point used by the pipeline registers
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    // Assemble the architectural SR word; unimplemented bits read 0
    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[SR_IM_HI:SR_IM_LO] = im;
        w[SR_EXL]            = exl;
        w[SR_IE]             = ie;
        return w;
    endfunction

    // Assemble the architectural Cause word; unimplemented bits read 0
    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] exc_code);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[CAUSE_BD]                = bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
        w[CAUSE_EC_HI:CAUSE_EC_LO] = exc_code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational arbitration of hardware interrupts against synchronous
// exceptions. EXL blocks both sources, so handlers never nest.
module cp0_req_gen
    import cp0_pkg::*;
(
    input  logic       ie,
    input  logic       exl,
    input  logic [5:0] im,
    input  logic [5:0] hw_int,
    input  logic [4:0] exc_code_in,
    output logic       int_req,
    output logic       exc_req,
    output logic       req
);

    logic int_req_s;
    logic exc_req_s;

    // Decide whether an interrupt and/or an exception is being taken
    always_comb begin
        int_req_s = 1'b0;
        exc_req_s = 1'b0;
        if (!exl) begin
            int_req_s = ie & (|(im & hw_int));
            exc_req_s = (exc_code_in != EXC_INT);
        end else begin
            int_req_s = 1'b0;
            exc_req_s = 1'b0;
        end
    end

    assign int_req = int_req_s;
    assign exc_req = exc_req_s;
    assign req     = int_req_s | exc_req_s;

endmodule

// File: rtl/cp0.sv
// Coprocessor-0 at the M stage: holds SR, Cause, EPC and PRId, raises the
// pipeline flush request and services mtc0/mfc0/eret.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h2022_0707,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic        Req
);

    // Architectural state
    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;

    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;
    logic        sr_we_s;
    logic        epc_we_s;
    logic [31:0] rdata_s;

    // HANDLER_PC is only exported to the pipeline registers
    logic unused_handler_s;
    assign unused_handler_s = ^HANDLER_PC;

    cp0_req_gen u_req_gen (
        .ie          (ie_r),
        .exl         (exl_r),
        .im          (im_r),
        .hw_int      (HWInt),
        .exc_code_in (ExcCodeIn),
        .int_req     (int_req_s),
        .exc_req     (exc_req_s),
        .req         (req_s)
    );

    // mtc0 write strobes; a flush in the same cycle discards the write
    always_comb begin
        sr_we_s  = 1'b0;
        epc_we_s = 1'b0;
        if (en && !req_s) begin
            sr_we_s  = (CP0Add == REG_SR);
            epc_we_s = (CP0Add == REG_EPC);
        end else begin
            sr_we_s  = 1'b0;
            epc_we_s = 1'b0;
        end
    end

    // State update: exception entry beats eret, which beats plain mtc0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_r       <= 6'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            ip_r       <= 6'd0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'h0000_0000;
        end else begin
            ip_r <= HWInt;
            if (req_s) begin
                exl_r      <= 1'b1;
                bd_r       <= BDIn;
                exc_code_r <= int_req_s ? EXC_INT : ExcCodeIn;
                epc_r      <= BDIn ? (VPC - 32'd4) : VPC;
            end else begin
                if (sr_we_s) begin
                    im_r <= CP0In[SR_IM_HI:SR_IM_LO];
                    ie_r <= CP0In[SR_IE];
                end
                // eret wins over a simultaneous mtc0 for the EXL bit only
                if (EXLClr) begin
                    exl_r <= 1'b0;
                end else if (sr_we_s) begin
                    exl_r <= CP0In[SR_EXL];
                end
                if (epc_we_s) begin
                    epc_r <= CP0In;
                end
            end
        end
    end

    // mfc0 read mux; unimplemented indices read 0
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (CP0Add)
            REG_SR:    rdata_s = pack_sr(im_r, exl_r, ie_r);
            REG_CAUSE: rdata_s = pack_cause(bd_r, ip_r, exc_code_r);
            REG_EPC:   rdata_s = epc_r;
            REG_PRID:  rdata_s = PRID_VAL;
            default:   rdata_s = 32'h0000_0000;
        endcase
    end

    assign CP0Out = rdata_s;
    assign EPCOut = epc_r;
    assign Req    = req_s;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0.
module tb_cp0;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic        Req;

    int tests = 0;
    int fails = 0;

    cp0 dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .CP0Out    (CP0Out),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en        = 1'b0;
        EXLClr    = 1'b0;
        ExcCodeIn = 5'd0;
        BDIn      = 1'b0;
        CP0In     = 32'h0000_0000;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        CP0Add = a;
        #1;
        d = CP0Out;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en     = 1'b1;
        CP0Add = a;
        CP0In  = d;
        tick();
        en     = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rd(5'd15, d); tests++;
        if (d !== 32'h2022_0707) begin fails++; $display("FAIL reset_prid got %h exp %h", d, 32'h2022_0707); end
        rd(5'd12, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_sr got %h exp 0", d); end
        rd(5'd13, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_cause got %h exp 0", d); end
        rd(5'd14, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_epc got %h exp 0", d); end
        rd(5'd3, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_idx3 got %h exp 0", d); end
        tests++;
        if (Req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", Req); end
        tests++;
        if (EPCOut !== 32'h0) begin fails++; $display("FAIL reset_epcout got %h exp 0", EPCOut); end
    endtask

    task automatic test_mtc0_readback();
        logic [31:0] d;
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL cause_write_ignored got %h exp 0", d); end
        mtc0(5'd15, 32'h0000_0000);
        rd(5'd15, d); tests++;
        if (d !== 32'h2022_0707) begin fails++; $display("FAIL prid_write_ignored got %h exp %h", d, 32'h2022_0707); end
        mtc0(5'd12, 32'hFFFF_FC01);
        rd(5'd12, d); tests++;
        if (d !== 32'h0000_FC01) begin fails++; $display("FAIL sr_write got %h exp %h", d, 32'h0000_FC01); end
    endtask

    task automatic test_interrupt();
        logic [31:0] d;
        VPC   = 32'h0000_1000;
        HWInt = 6'b000100;
        #1; tests++;
        if (Req !== 1'b1) begin fails++; $display("FAIL int_req got %b exp 1", Req); end
        tick();
        rd(5'd13, d); tests++;
        if (d !== 32'h0000_1000) begin fails++; $display("FAIL int_cause got %h exp %h", d, 32'h0000_1000); end
        rd(5'd12, d); tests++;
        if (d !== 32'h0000_FC03) begin fails++; $display("FAIL int_sr got %h exp %h", d, 32'h0000_FC03); end
        rd(5'd14, d); tests++;
        if (d !== 32'h0000_1000) begin fails++; $display("FAIL int_epc got %h exp %h", d, 32'h0000_1000); end
        tests++;
        if (Req !== 1'b0) begin fails++; $display("FAIL int_no_nest got %b exp 0", Req); end
        ExcCodeIn = EXC_OV;
        #1; tests++;
        if (Req !== 1'b0) begin fails++; $display("FAIL exc_no_nest got %b exp 0", Req); end
        ExcCodeIn = 5'd0;
        HWInt     = 6'b000000;
        EXLClr    = 1'b1;
        tick();
        idle();
        rd(5'd12, d); tests++;
        if (d !== 32'h0000_FC01) begin fails++; $display("FAIL eret_sr got %h exp %h", d, 32'h0000_FC01); end
    endtask

    task automatic test_exception();
        logic [31:0] d;
        mtc0(5'd12, 32'h0000_FC00);
        ExcCodeIn = EXC_OV;
        BDIn      = 1'b1;
        VPC       = 32'h0000_3010;
        #1; tests++;
        if (Req !== 1'b1) begin fails++; $display("FAIL exc_req got %b exp 1", Req); end
        tick();
        idle();
        rd(5'd14, d); tests++;
        if (d !== 32'h0000_300C) begin fails++; $display("FAIL exc_epc got %h exp %h", d, 32'h0000_300C); end
        rd(5'd13, d); tests++;
        if (d !== 32'h8000_0030) begin fails++; $display("FAIL exc_cause got %h exp %h", d, 32'h8000_0030); end
        tests++;
        if (EPCOut !== 32'h0000_300C) begin fails++; $display("FAIL exc_epcout got %h exp %h", EPCOut, 32'h0000_300C); end
        EXLClr = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_priority();
        logic [31:0] d;
        mtc0(5'd12, 32'h0000_FC01);
        HWInt     = 6'b000100;
        ExcCodeIn = EXC_RI;
        VPC       = 32'h0000_2000;
        #1; tests++;
        if (Req !== 1'b1) begin fails++; $display("FAIL prio_req got %b exp 1", Req); end
        tick();
        idle();
        HWInt = 6'b000000;
        rd(5'd13, d); tests++;
        if (d !== 32'h0000_1000) begin fails++; $display("FAIL prio_cause got %h exp %h", d, 32'h0000_1000); end
        rd(5'd14, d); tests++;
        if (d !== 32'h0000_2000) begin fails++; $display("FAIL prio_epc got %h exp %h", d, 32'h0000_2000); end
    endtask

    task automatic test_eret_mtc0();
        logic [31:0] d;
        // EXL is 1 here: eret plus mtc0 EPC both take effect
        EXLClr = 1'b1;
        en     = 1'b1;
        CP0Add = 5'd14;
        CP0In  = 32'h1234_5678;
        #1; tests++;
        if (Req !== 1'b0) begin fails++; $display("FAIL eret_mtc0_req got %b exp 0", Req); end
        tick();
        idle();
        rd(5'd12, d); tests++;
        if (d !== 32'h0000_FC01) begin fails++; $display("FAIL eret_mtc0_sr got %h exp %h", d, 32'h0000_FC01); end
        rd(5'd14, d); tests++;
        if (d !== 32'h1234_5678) begin fails++; $display("FAIL eret_mtc0_epc got %h exp %h", d, 32'h1234_5678); end
        // EXL is 0: an exception in the same cycle drops the mtc0
        ExcCodeIn = EXC_ADEL;
        VPC       = 32'h0000_5000;
        BDIn      = 1'b0;
        EXLClr    = 1'b1;
        en        = 1'b1;
        CP0Add    = 5'd14;
        CP0In     = 32'hDEAD_BEEF;
        tick();
        idle();
        rd(5'd14, d); tests++;
        if (d !== 32'h0000_5000) begin fails++; $display("FAIL req_drops_mtc0_epc got %h exp %h", d, 32'h0000_5000); end
        rd(5'd13, d); tests++;
        if (d !== 32'h0000_0010) begin fails++; $display("FAIL req_drops_cause got %h exp %h", d, 32'h0000_0010); end
        rd(5'd12, d); tests++;
        if (d !== 32'h0000_FC03) begin fails++; $display("FAIL req_drops_sr got %h exp %h", d, 32'h0000_FC03); end
        // EXL is 1: mtc0 SR with EXL=1 alongside eret ends with EXL=0
        EXLClr = 1'b1;
        en     = 1'b1;
        CP0Add = 5'd12;
        CP0In  = 32'h0000_0403;
        tick();
        idle();
        rd(5'd12, d); tests++;
        if (d !== 32'h0000_0401) begin fails++; $display("FAIL eret_mtc0_sr_exl got %h exp %h", d, 32'h0000_0401); end
    endtask

    task automatic test_vpc_wrap();
        logic [31:0] d;
        ExcCodeIn = EXC_SYSCALL;
        BDIn      = 1'b1;
        VPC       = 32'h0000_0000;
        tick();
        idle();
        rd(5'd14, d); tests++;
        if (d !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_epc got %h exp %h", d, 32'hFFFF_FFFC); end
        rd(5'd13, d); tests++;
        if (d !== 32'h8000_0020) begin fails++; $display("FAIL wrap_cause got %h exp %h", d, 32'h8000_0020); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        // EXL is 1 from the previous exception
        HWInt = 6'b000001;
        @(negedge clk);
        reset = 1'b1;
        #1; tests++;
        if (Req !== 1'b0) begin fails++; $display("FAIL areset_req got %b exp 0", Req); end
        rd(5'd12, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL areset_sr got %h exp 0", d); end
        rd(5'd13, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL areset_cause got %h exp 0", d); end
        tests++;
        if (EPCOut !== 32'h0) begin fails++; $display("FAIL areset_epcout got %h exp 0", EPCOut); end
        tick();
        reset = 1'b0;
        HWInt = 6'b000000;
        tick();
    endtask

    // Run all scenarios in sequence and report
    initial begin
        reset  = 1'b1;
        idle();
        HWInt  = 6'b000000;
        CP0Add = 5'd0;
        VPC    = 32'h0000_0000;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_mtc0_readback();
        test_interrupt();
        test_exception();
        test_priority();
        test_eret_mtc0();
        test_vpc_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline, located at the M stage. It holds SR, Cause, EPC and PRId, and arbitrates hardware interrupts against synchronous exception codes carried down the pipeline. It drives the single `Req` flush that the D/E, E/M and M/W pipeline registers consume, forcing their PC to the handler address 0x0000_4180. It also services `mtc0` and `mfc0` and supplies EPC for `eret`.

## Interface
Parameters:
- `PRID_VAL`, default 32'h2022_0707: constant value returned when reading PRId (reg 15).
- `HANDLER_PC`, default 32'h0000_4180: exported for pipeline registers; not used internally.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `en` in 1: `mtc0` write enable from the M stage.
- `CP0Add` in 5: register index for both read and write.
- `CP0In` in 32: `mtc0` write data.
- `VPC` in 32: PC of the instruction currently in the M stage.
- `BDIn` in 1: the M-stage instruction is in a branch delay slot.
- `ExcCodeIn` in 5: accumulated exception code of the M-stage instruction; 0 means none.
- `HWInt` in 6: hardware interrupt lines (timer0, timer1, external, ...).
- `EXLClr` in 1: `eret` in the M stage.
- `CP0Out` out 32: combinational read data for `mfc0`.
- `EPCOut` out 32: current EPC, used as the `eret` target.
- `Req` out 1: combinational flush/redirect request.

## Operation
Register fields:
- SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
- EPC (14): full 32 bits.
- PRId (15): `PRID_VAL`.
- Any other index reads 0.

Request generation (combinational from current state and inputs):
- IntReq = IE & !EXL & |(IM & HWInt).
- ExcReq = !EXL & (ExcCodeIn != 0).
- Req = IntReq | ExcReq. Interrupt has priority: if both, ExcCode recorded is 0.

Posedge update, in priority order:
1. Req=1: EXL<=1; Cause.BD<=BDIn; Cause.ExcCode<= IntReq ? 0 : ExcCodeIn; EPC<= BDIn ? VPC-4 : VPC. An `mtc0` or `EXLClr` in the same cycle is discarded.
2. Else if EXLClr=1: EXL<=0. A simultaneous `mtc0` is still applied, except to the EXL bit, which ends at 0.
3. Else if en=1:
   - CP0Add=12: writes IM, EXL, IE only.
   - CP0Add=14: writes EPC.
   - Writes to 13, 15 or other indices are ignored.

Independent of the above:
- Cause.IP<=HWInt every cycle, including when Req is asserted.
- `EPCOut` = EPC register as stored; there is no alignment masking.
- VPC-4 is 32-bit modular arithmetic (VPC=0 gives 32'hFFFF_FFFC).

## Timing
- Reset values: SR=0, Cause=0, EPC=0. Outputs after reset: `CP0Out`=0 except PRId reads; `EPCOut`=0; `Req`=0.
- `Req` and `CP0Out` are zero-latency combinational paths. New register values are visible one cycle after the capturing edge.
- `mtc0` followed by `mfc0` of the same register in the next cycle returns the new value.
- While EXL=1, `Req` stays 0 regardless of HWInt or ExcCodeIn (no nesting).
- A reset asserted mid-handler clears EXL and EPC asynchronously; `Req` is 0 during reset.

## Structure
Shared package `cp0_pkg`:
- Register indices SR=12, CAUSE=13, EPC=14, PRID=15.
- ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
- Field bit positions.
- `HANDLER_PC`.

One natural sub-module: `cp0_req_gen`, the purely combinational IntReq/ExcReq arbitration. All state stays in `cp0`.

## Test plan
- Reset, then read each index: reg15 reads `PRID_VAL`; regs 12/13/14 and index 3 read 0; `Req`=0.
- `mtc0` SR with 32'h0000_fc01, then HWInt=6'b000100: `Req`=1 in the same cycle. Next cycle: EXL=1, Cause=32'h0000_1000, EPC=VPC, `Req`=0.
- ExcCodeIn=12, BDIn=1, VPC=32'h3010 with IE=0: `Req`=1. Next cycle: EPC=32'h300c, Cause.BD=1, ExcCode=12.
- HWInt interrupt and ExcCodeIn=10 in the same cycle with IE/IM set: recorded ExcCode=0 (interrupt wins).
- EXL=1, then EXLClr=1 and `mtc0` EPC in the same cycle: EXL=0 and EPC=written value. Same stimulus with `Req` forced via exception while EXL=0: the `mtc0` write is dropped.
- Assert reset asynchronously between edges while EXL=1: SR, Cause and EPC read 0 immediately, without waiting for a clock edge.
